// File: rtl/sevenseg_scan_driver_pkg.sv
// Shared definitions for the seven-segment scan driver: digit count,
// blanked-segment pattern, hex-to-segment table and slot phase type.
// Latency: n/a (constants and a pure function). Backpressure: n/a.
package sevenseg_scan_driver_pkg;

  localparam int NUM_DIGITS = 8;

  // Active-low cathode pattern with every segment off.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-high segments {g,f,e,d,c,b,a}, indexed by nibble value.
  // Listed from entry 15 (F) down to entry 0 (0).
  localparam logic [15:0][6:0] HEX7_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Within a slot: anodes held off first, then the selected digit is driven.
  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } slot_phase_e;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    return HEX7_TABLE[nib];
  endfunction

endpackage

// File: rtl/sevenseg_scan_driver_if.sv
// Display content bus from the register block to the scan driver.
// Latency: n/a (wires only). Backpressure: none; the consumer samples once per frame.
// Signals: display (8 nibbles), digit_enable, decimal_point, brightness.
interface sevenseg_scan_driver_if
  import sevenseg_scan_driver_pkg::*;
#(
  parameter int BRIGHT_BITS = 3
);

  logic [4*NUM_DIGITS-1:0] display;
  logic [NUM_DIGITS-1:0]   digit_enable;
  logic [NUM_DIGITS-1:0]   decimal_point;
  logic [BRIGHT_BITS-1:0]  brightness;

  modport master (
    output display,
    output digit_enable,
    output decimal_point,
    output brightness
  );

  modport slave (
    input display,
    input digit_enable,
    input decimal_point,
    input brightness
  );

endinterface

// File: rtl/sevenseg_scan_driver_hex_to_7seg.sv
// Nibble to active-high seven-segment pattern {g,f,e,d,c,b,a}, covering 0-9 and A-F.
// Latency: combinational. Backpressure: none.
// Ports: nibble_i (4-bit value), seg_o (7-bit active-high segments).
module hex_to_7seg
  import sevenseg_scan_driver_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex7(nibble_i);

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed 8-digit common-anode display driver with per-frame input latching,
// anti-ghosting blank gap per slot and PWM brightness.
// Latency: all pins registered, one cycle behind counter/shadow state. Backpressure: none.
// Ports: clk, resetn (async active-low), disp_if (display/digit_enable/decimal_point/brightness),
//        frame_strobe (1-cycle pulse per frame load), seg/dp/anode (active-low board pins).
module sevenseg_scan_driver
  import sevenseg_scan_driver_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int DIGIT_HZ     = 1000,
  parameter int BLANK_CYCLES = 64,
  parameter int BRIGHT_BITS  = 3
) (
  input  logic                    clk,
  input  logic                    resetn,
  sevenseg_scan_driver_if.slave   disp_if,
  output logic                    frame_strobe,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode
);

  localparam int SLOT_CYCLES = CLK_HZ / DIGIT_HZ;
  localparam int SLOT_W      = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int DIGIT_W     = $clog2(NUM_DIGITS);

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [SLOT_W-1:0]  BLANK_END  = SLOT_W'(BLANK_CYCLES);
  localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(NUM_DIGITS - 1);

  // A blank gap covering the whole slot would never light anything.
  generate
    if (BLANK_CYCLES >= SLOT_CYCLES) begin : g_bad_blank
      $error("BLANK_CYCLES must be smaller than CLK_HZ/DIGIT_HZ");
    end
  endgenerate

  // Scan counters
  logic [SLOT_W-1:0]      slot_cnt_q,  slot_cnt_d;
  logic [DIGIT_W-1:0]     digit_q,     digit_d;
  logic [BRIGHT_BITS-1:0] pwm_cnt_q,   pwm_cnt_d;

  // Frame shadow of the input bus
  logic [4*NUM_DIGITS-1:0] shadow_disp_q,   shadow_disp_d;
  logic [NUM_DIGITS-1:0]   shadow_en_q,     shadow_en_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q,     shadow_dp_d;
  logic [BRIGHT_BITS-1:0]  shadow_bright_q, shadow_bright_d;

  // Output registers
  logic                  frame_strobe_q, frame_strobe_d;
  logic [6:0]            seg_q,          seg_d;
  logic                  dp_q,           dp_d;
  logic [NUM_DIGITS-1:0] anode_q,        anode_d;

  slot_phase_e phase;
  logic        slot_wrap;
  logic        frame_wrap;
  logic        digit_on;
  logic        pwm_on;
  logic [3:0]  cur_nibble;
  logic [6:0]  cur_seg_hi;

  assign cur_nibble = shadow_disp_q[{digit_q, 2'b00} +: 4];

  hex_to_7seg u_hex (
    .nibble_i (cur_nibble),
    .seg_o    (cur_seg_hi)
  );

  always_comb begin
    slot_cnt_d      = slot_cnt_q;
    digit_d         = digit_q;
    pwm_cnt_d       = pwm_cnt_q + BRIGHT_BITS'(1);
    shadow_disp_d   = shadow_disp_q;
    shadow_en_d     = shadow_en_q;
    shadow_dp_d     = shadow_dp_q;
    shadow_bright_d = shadow_bright_q;
    frame_strobe_d  = 1'b0;
    seg_d           = SEG_OFF;
    dp_d            = 1'b1;
    anode_d         = '1;
    phase           = PH_BLANK;

    slot_wrap  = (slot_cnt_q == SLOT_LAST);
    frame_wrap = slot_wrap && (digit_q == DIGIT_LAST);

    if (slot_wrap) begin
      slot_cnt_d = '0;
      digit_d    = frame_wrap ? '0 : digit_q + DIGIT_W'(1);
    end else begin
      slot_cnt_d = slot_cnt_q + SLOT_W'(1);
    end

    // Latch a whole frame at once so a digit never mixes old and new content.
    if (frame_wrap) begin
      shadow_disp_d   = disp_if.display;
      shadow_en_d     = disp_if.digit_enable;
      shadow_dp_d     = disp_if.decimal_point;
      shadow_bright_d = disp_if.brightness;
      frame_strobe_d  = 1'b1;
    end

    phase    = (slot_cnt_q < BLANK_END) ? PH_BLANK : PH_DRIVE;
    digit_on = shadow_en_q[digit_q];
    pwm_on   = (pwm_cnt_q <= shadow_bright_q);

    // Cathodes carry the digit for the whole slot, so they are settled
    // before the anode turns on at the end of the blank gap.
    if (digit_on) begin
      seg_d = ~cur_seg_hi;
      dp_d  = ~shadow_dp_q[digit_q];
    end

    if (phase == PH_DRIVE && digit_on && pwm_on) begin
      anode_d[digit_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // Parked on the last slot of the last digit so the first edge loads a frame.
      slot_cnt_q      <= SLOT_LAST;
      digit_q         <= DIGIT_LAST;
      pwm_cnt_q       <= '0;
      shadow_disp_q   <= '0;
      shadow_en_q     <= '0;
      shadow_dp_q     <= '0;
      shadow_bright_q <= '0;
      frame_strobe_q  <= 1'b0;
      seg_q           <= SEG_OFF;
      dp_q            <= 1'b1;
      anode_q         <= '1;
    end else begin
      slot_cnt_q      <= slot_cnt_d;
      digit_q         <= digit_d;
      pwm_cnt_q       <= pwm_cnt_d;
      shadow_disp_q   <= shadow_disp_d;
      shadow_en_q     <= shadow_en_d;
      shadow_dp_q     <= shadow_dp_d;
      shadow_bright_q <= shadow_bright_d;
      frame_strobe_q  <= frame_strobe_d;
      seg_q           <= seg_d;
      dp_q            <= dp_d;
      anode_q         <= anode_d;
    end
  end

  assign frame_strobe = frame_strobe_q;
  assign seg          = seg_q;
  assign dp           = dp_q;
  assign anode        = anode_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver with SLOT_CYCLES=10, BLANK_CYCLES=2, BRIGHT_BITS=3.
// Frame = 80 cycles; k counts cycles after a strobe, pins at k show slot position k-1.
module tb_sevenseg_scan_driver;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       frame_strobe;
  logic [6:0] seg;
  logic       dp;
  logic [7:0] anode;

  int n_checks = 0;
  int n_pass   = 0;

  // Active-low segment patterns per digit, hand-decoded.
  logic [6:0] seg_1234 [8];
  logic [6:0] seg_dead [8];

  always #5 clk = ~clk;

  sevenseg_scan_driver_if #(.BRIGHT_BITS(3)) bus ();

  sevenseg_scan_driver #(
    .CLK_HZ       (1000),
    .DIGIT_HZ     (100),
    .BLANK_CYCLES (2),
    .BRIGHT_BITS  (3)
  ) u_dut (
    .clk          (clk),
    .resetn       (resetn),
    .disp_if      (bus),
    .frame_strobe (frame_strobe),
    .seg          (seg),
    .dp           (dp),
    .anode        (anode)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] an_low(input int d);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << d);
  endfunction

  task automatic test_reset();
    int k;
    resetn = 1'b0;
    bus.display       = 32'h12345678;
    bus.digit_enable  = 8'hFF;
    bus.decimal_point = 8'h00;
    bus.brightness    = 3'd7;
    repeat (3) step();
    n_checks++; if (anode !== 8'hFF) $display("FAIL rst_anode got %h want ff", anode); else n_pass++;
    n_checks++; if (seg !== 7'h7F) $display("FAIL rst_seg got %h want 7f", seg); else n_pass++;
    n_checks++; if (dp !== 1'b1) $display("FAIL rst_dp got %b want 1", dp); else n_pass++;
    n_checks++; if (frame_strobe !== 1'b0) $display("FAIL rst_strobe got %b want 0", frame_strobe); else n_pass++;
    resetn = 1'b1;
    step();
    n_checks++; if (frame_strobe !== 1'b1) $display("FAIL first_strobe got %b want 1", frame_strobe); else n_pass++;
    step();
    n_checks++; if (frame_strobe !== 1'b0) $display("FAIL strobe_width got %b want 0", frame_strobe); else n_pass++;
    n_checks++; if (anode !== 8'hFF) $display("FAIL gap_k1 got %h want ff", anode); else n_pass++;
    step();
    n_checks++; if (anode !== 8'hFF) $display("FAIL gap_k2 got %h want ff", anode); else n_pass++;
    step();
    n_checks++; if (anode !== 8'hFE) $display("FAIL first_fe got %h want fe", anode); else n_pass++;
    k = 3;
    do begin
      step();
      k++;
    end while (frame_strobe !== 1'b1 && k < 200);
    n_checks++; if (k != 80) $display("FAIL strobe_period got %0d want 80", k); else n_pass++;
  endtask

  task automatic test_scan();
    int p, d, s;
    logic [7:0] exp_an;
    for (int k = 1; k <= 80; k++) begin
      step();
      p = k - 1; d = p / 10; s = p % 10;
      exp_an = (s < 2) ? 8'hFF : an_low(d);
      n_checks++; if (anode !== exp_an) $display("FAIL scan_anode k=%0d got %h want %h", k, anode, exp_an); else n_pass++;
      n_checks++; if (seg !== seg_1234[d]) $display("FAIL scan_seg k=%0d got %h want %h", k, seg, seg_1234[d]); else n_pass++;
      n_checks++; if (dp !== 1'b1) $display("FAIL scan_dp k=%0d got %b want 1", k, dp); else n_pass++;
      n_checks++; if (frame_strobe !== (k == 80)) $display("FAIL scan_strobe k=%0d got %b want %b", k, frame_strobe, k == 80); else n_pass++;
    end
  endtask

  task automatic test_no_tearing();
    int d;
    for (int k = 1; k <= 80; k++) begin
      step();
      d = (k - 1) / 10;
      if (k == 35) bus.display = 32'hDEADBEEF;
      n_checks++; if (seg !== seg_1234[d]) $display("FAIL tear_old k=%0d got %h want %h", k, seg, seg_1234[d]); else n_pass++;
    end
    n_checks++; if (frame_strobe !== 1'b1) $display("FAIL tear_strobe got %b want 1", frame_strobe); else n_pass++;
    for (int k = 1; k <= 80; k++) begin
      step();
      d = (k - 1) / 10;
      n_checks++; if (seg !== seg_dead[d]) $display("FAIL tear_new k=%0d got %h want %h", k, seg, seg_dead[d]); else n_pass++;
    end
  endtask

  task automatic test_brightness();
    int lows [8];
    int d;
    bus.brightness = 3'd0;
    repeat (80) step();
    n_checks++; if (frame_strobe !== 1'b1) $display("FAIL dim_load_strobe got %b want 1", frame_strobe); else n_pass++;
    for (int i = 0; i < 8; i++) lows[i] = 0;
    for (int k = 1; k <= 80; k++) begin
      step();
      d = (k - 1) / 10;
      n_checks++;
      if (anode !== 8'hFF && anode !== an_low(d)) $display("FAIL dim_anode k=%0d got %h want ff or %h", k, anode, an_low(d));
      else n_pass++;
      if (anode === an_low(d)) lows[d]++;
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (lows[i] != 1) $display("FAIL dim_on_cycles digit=%0d got %0d want 1", i, lows[i]); else n_pass++;
    end
  endtask

  task automatic test_enable_dp();
    int p, d, s;
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    bus.brightness    = 3'd7;
    bus.digit_enable  = 8'h01;
    bus.decimal_point = 8'h81;
    repeat (80) step();
    n_checks++; if (frame_strobe !== 1'b1) $display("FAIL en_load_strobe got %b want 1", frame_strobe); else n_pass++;
    for (int k = 1; k <= 80; k++) begin
      step();
      p = k - 1; d = p / 10; s = p % 10;
      exp_an  = (d == 0 && s >= 2) ? 8'hFE : 8'hFF;
      exp_seg = (d == 0) ? 7'h0E : 7'h7F;
      exp_dp  = (d == 0) ? 1'b0 : 1'b1;
      n_checks++; if (anode !== exp_an) $display("FAIL en_anode k=%0d got %h want %h", k, anode, exp_an); else n_pass++;
      n_checks++; if (seg !== exp_seg) $display("FAIL en_seg k=%0d got %h want %h", k, seg, exp_seg); else n_pass++;
      n_checks++; if (dp !== exp_dp) $display("FAIL en_dp k=%0d got %b want %b", k, dp, exp_dp); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int k;
    bus.display       = 32'h12345678;
    bus.digit_enable  = 8'hFF;
    bus.decimal_point = 8'h00;
    repeat (80) step();
    n_checks++; if (frame_strobe !== 1'b1) $display("FAIL mid_load_strobe got %b want 1", frame_strobe); else n_pass++;
    repeat (45) step();
    n_checks++; if (anode !== 8'hEF) $display("FAIL mid_pre_anode got %h want ef", anode); else n_pass++;
    n_checks++; if (seg !== 7'h19) $display("FAIL mid_pre_seg got %h want 19", seg); else n_pass++;
    resetn = 1'b0;
    #1;
    n_checks++; if (anode !== 8'hFF) $display("FAIL mid_rst_anode got %h want ff", anode); else n_pass++;
    n_checks++; if (seg !== 7'h7F) $display("FAIL mid_rst_seg got %h want 7f", seg); else n_pass++;
    n_checks++; if (dp !== 1'b1) $display("FAIL mid_rst_dp got %b want 1", dp); else n_pass++;
    repeat (2) step();
    resetn = 1'b1;
    step();
    n_checks++; if (frame_strobe !== 1'b1) $display("FAIL mid_restart_strobe got %b want 1", frame_strobe); else n_pass++;
    step();
    n_checks++; if (seg !== 7'h00) $display("FAIL mid_restart_seg got %h want 00", seg); else n_pass++;
    repeat (2) step();
    n_checks++; if (anode !== 8'hFE) $display("FAIL mid_restart_anode got %h want fe", anode); else n_pass++;
    k = 3;
    do begin
      step();
      k++;
    end while (frame_strobe !== 1'b1 && k < 200);
    n_checks++; if (k != 80) $display("FAIL mid_period got %0d want 80", k); else n_pass++;
  endtask

  initial begin
    seg_1234 = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    seg_dead = '{7'h0E, 7'h06, 7'h06, 7'h03, 7'h21, 7'h08, 7'h06, 7'h21};
    bus.display       = '0;
    bus.digit_enable  = '0;
    bus.decimal_point = '0;
    bus.brightness    = '0;
    test_reset();
    test_scan();
    test_no_tearing();
    test_brightness();
    test_enable_dp();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
